// File: rtl/i2c_chunk_arb_pkg.sv
// i2c_chunk_arb_pkg: dpram quarter map and time-slot codes shared by the arbiter.
package i2c_chunk_arb_pkg;
  localparam logic [1:0] Q_PROG = 2'd0;
  localparam logic [1:0] Q_TRACE = 2'd1;
  localparam logic [1:0] Q_VIS = 2'd2;
  localparam logic [1:0] Q_WORK = 2'd3;
  typedef enum logic [2:0] {
    SLOT_POP0, SLOT_TRACE, SLOT_POP2, SLOT_RESULT,
    SLOT_POP4, SLOT_PADDR, SLOT_POP6, SLOT_PDATA
  } slot_e;
  function automatic logic is_pop_slot(input slot_e s);
    return !s[0];
  endfunction
endpackage

// File: rtl/dpram.sv
// dpram: dual-port RAM; port A writes or reads (read held until next read), port B reads every cycle.
module dpram #(
  parameter int aw = 12,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic [aw-1:0] addra_i,
  input  logic [dw-1:0] dina_i,
  input  logic          wena_i,
  input  logic          rena_i,
  output logic [dw-1:0] douta_o,
  input  logic [aw-1:0] addrb_i,
  output logic [dw-1:0] doutb_o
);
  logic [dw-1:0] mem_q [2**aw];
  always_ff @(posedge clk) begin
    if (wena_i) mem_q[addra_i] <= dina_i;
    if (rena_i) douta_o <= mem_q[addra_i];
    doutb_o <= mem_q[addrb_i];
  end
endmodule

// File: rtl/i2c_chunk_arb.sv
// i2c_chunk_arb: time-sliced arbiter sharing one dpram between local bus, trace, results and program fetch.
module i2c_chunk_arb
  import i2c_chunk_arb_pkg::*;
#(
  parameter int aw = 12,
  parameter int tick_scale = 6,
  parameter int wdepth = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [aw-1:0] lb_addr,
  input  logic [7:0]    lb_din,
  input  logic          lb_write,
  output logic [7:0]    lb_dout,
  input  logic          freeze,
  output logic          updated,
  output logic          err_flag,
  output logic          tick,
  input  logic [aw-3:0] p_addr,
  output logic [7:0]    p_data,
  input  logic [7:0]    result,
  input  logic          result_stb,
  input  logic [aw-3:0] result_p,
  input  logic          buffer_flip,
  input  logic          trig_analyz,
  input  logic [7:0]    trace,
  input  logic          trace_push,
  output logic          trace_run
);
  localparam int iw = wdepth > 1 ? $clog2(wdepth) : 1;
  localparam int cw = $clog2(wdepth) + 1;
  logic [tick_scale-1:0] acc_q;
  logic tick_q;
  logic [aw+7:0] fifo_q [wdepth];
  logic [iw-1:0] wp_q, rp_q;
  logic [cw-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [7:0] trace_hold_q;
  logic trace_pend_q, trace_pend_d;
  logic [aw-3:0] trace_a_q, trace_a_d;
  logic trace_run_q, trace_run_d;
  logic [7:0] res_q;
  logic [aw-3:0] res_p_q;
  logic res_pend_q, res_pend_d;
  logic pp_q, pp_d, defer_q, defer_d, updated_q, updated_d;
  logic freeze_r_q, freeze_d_q;
  logic [7:0] p_data_q;
  slot_e slot;
  logic pop, push, tr_wr, res_wr, fall, do_flip, a_we, a_re;
  logic [aw-1:0] a_addr, b_addr;
  logic [7:0] a_din, a_dout;
  always_comb begin
    slot = slot_e'(acc_q[2:0]);
    pop = is_pop_slot(slot) && cnt_q != '0;
    push = lb_write && (cnt_q != cw'(wdepth) || pop);
    tr_wr = slot == SLOT_TRACE && trace_pend_q;
    res_wr = slot == SLOT_RESULT && res_pend_q;
    a_we = !rst && (pop || tr_wr || res_wr);
    a_re = slot == SLOT_PADDR;
    a_addr = pop ? fifo_q[rp_q][aw+7:8] : tr_wr ? {Q_TRACE, trace_a_q} :
             res_wr ? {pp_q ? Q_WORK : Q_VIS, res_p_q} : {Q_PROG, p_addr};
    a_din = pop ? fifo_q[rp_q][7:0] : tr_wr ? trace_hold_q : res_q;
    b_addr = {lb_addr[aw-1], lb_addr[aw-2] ^ (lb_addr[aw-1] && !pp_q), lb_addr[aw-3:0]};
    cnt_d = cnt_q + cw'(push) - cw'(pop);
    err_d = err_q || (lb_write && !push);
    trace_pend_d = trace_push || (trace_pend_q && !tr_wr);
    trace_a_d = tr_wr ? trace_a_q + 1'b1 : trace_a_q;
    trace_run_d = trig_analyz || (trace_run_q && !(tr_wr && &trace_a_q));
    res_pend_d = result_stb || (res_pend_q && !res_wr);
    // a flip landing on the freeze release edge merges with any deferred one
    fall = freeze_d_q && !freeze_r_q;
    do_flip = fall ? defer_q || buffer_flip : buffer_flip && !freeze_d_q;
    pp_d = pp_q ^ do_flip;
    defer_d = !fall && (defer_q || (buffer_flip && freeze_d_q));
    updated_d = do_flip || (updated_q && !fall);
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= {lb_addr, lb_din};
    if (trace_push) trace_hold_q <= trace;
    if (result_stb) begin
      res_q <= result;
      res_p_q <= result_p;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      tick_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      trace_pend_q <= 1'b0;
      trace_a_q <= '0;
      trace_run_q <= 1'b0;
      res_pend_q <= 1'b0;
      pp_q <= 1'b0;
      defer_q <= 1'b0;
      updated_q <= 1'b0;
      freeze_r_q <= 1'b0;
      freeze_d_q <= 1'b0;
      p_data_q <= '0;
    end else begin
      acc_q <= acc_q + 1'b1;
      tick_q <= &acc_q;
      if (push) wp_q <= wdepth == 1 ? '0 : wp_q + 1'b1;
      if (pop) rp_q <= wdepth == 1 ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_d;
      err_q <= err_d;
      trace_pend_q <= trace_pend_d;
      trace_a_q <= trace_a_d;
      trace_run_q <= trace_run_d;
      res_pend_q <= res_pend_d;
      pp_q <= pp_d;
      defer_q <= defer_d;
      updated_q <= updated_d;
      freeze_r_q <= freeze;
      freeze_d_q <= freeze_r_q;
      if (slot == SLOT_PDATA) p_data_q <= a_dout;
    end
  end
  dpram #(.aw(aw), .dw(8)) u_ram (
    .clk     (clk),
    .addra_i (a_addr),
    .dina_i  (a_din),
    .wena_i  (a_we),
    .rena_i  (a_re),
    .douta_o (a_dout),
    .addrb_i (b_addr),
    .doutb_o (lb_dout)
  );
  assign tick = tick_q;
  assign err_flag = err_q;
  assign trace_run = trace_run_q;
  assign updated = updated_q;
  assign p_data = p_data_q;
endmodule
